// File: rtl/wt_cache_pkg.sv
// Shared types and constants for the write-through dcache replacement-state scheduler.
package wt_cache_pkg;

  localparam int unsigned DCACHE_CL_IDX_WIDTH = 8;
  localparam int unsigned DCACHE_SET_ASSOC    = 4;
  localparam int unsigned DCACHE_WAY_WIDTH    = $clog2(DCACHE_SET_ASSOC);
  localparam int unsigned REPL_DROP_CNT_W     = 16;

  typedef struct packed {
    logic [DCACHE_CL_IDX_WIDTH-1:0] idx;
    logic [DCACHE_WAY_WIDTH-1:0]    way;
  } repl_hint_t;

endpackage

// File: rtl/wt_dcache_repl_fifo.sv
// Circular hit-hint buffer with per-entry valid bits and a set-index invalidate.
// WT_DCACHE_REPL_COALESCE_EN enables matching the push data against valid entries.
import wt_cache_pkg::*;

module wt_dcache_repl_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           clear_i,
  input  logic                           push_i,
  input  logic [DCACHE_CL_IDX_WIDTH-1:0] push_idx_i,
  input  logic [DCACHE_WAY_WIDTH-1:0]    push_way_i,
  input  logic                           pop_i,
  input  logic                           inval_i,
  input  logic [DCACHE_CL_IDX_WIDTH-1:0] inval_idx_i,
  output logic                           match_o,
  output logic [DCACHE_CL_IDX_WIDTH-1:0] head_idx_o,
  output logic [DCACHE_WAY_WIDTH-1:0]    head_way_o,
  output logic                           head_valid_o,
  output logic                           empty_o,
  output logic                           full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  repl_hint_t           mem_q [DEPTH];
  logic [DEPTH-1:0]     valid_q;
  logic [PTR_W-1:0]     wptr_q, rptr_q;
  logic [PTR_W:0]       count_q;
  logic                 push_en, pop_en;

  assign empty_o      = (count_q == '0);
  assign full_o       = (count_q == (PTR_W+1)'(DEPTH));
  assign push_en      = push_i && !full_o;
  assign pop_en       = pop_i && !empty_o;
  assign head_idx_o   = mem_q[rptr_q].idx;
  assign head_way_o   = mem_q[rptr_q].way;
  assign head_valid_o = valid_q[rptr_q];

`ifdef WT_DCACHE_REPL_COALESCE_EN
  always_comb begin
    match_o = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (mem_q[i].idx == push_idx_i) && (mem_q[i].way == push_way_i)) begin
        match_o = 1'b1;
      end
    end
  end
`else
  assign match_o = 1'b0;
`endif

  // Valid bits are cleared on pop, so a set bit always marks an occupied slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      valid_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      valid_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (inval_i && (mem_q[i].idx == inval_idx_i)) begin
          valid_q[i] <= 1'b0;
        end
      end
      if (pop_en) begin
        valid_q[rptr_q] <= 1'b0;
        rptr_q          <= rptr_q + PTR_W'(1);
      end
      if (push_en) begin
        mem_q[wptr_q].idx <= push_idx_i;
        mem_q[wptr_q].way <= push_way_i;
        valid_q[wptr_q]   <= 1'b1;
        wptr_q            <= wptr_q + PTR_W'(1);
      end
      if (push_en && !pop_en) begin
        count_q <= count_q + (PTR_W+1)'(1);
      end else if (!push_en && pop_en) begin
        count_q <= count_q - (PTR_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/wt_dcache_repl_sched.sv
// Replacement-state update scheduler: miss passthrough, round-robin hit-hint buffering.
// WT_DCACHE_REPL_COALESCE_EN merges hints that duplicate a valid buffered entry.
import wt_cache_pkg::*;

module wt_dcache_repl_sched #(
  parameter int unsigned NUM_PORTS  = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     flush_i,
  input  logic [NUM_PORTS-1:0]                     hit_valid_i,
  input  logic [NUM_PORTS*DCACHE_CL_IDX_WIDTH-1:0] hit_idx_i,
  input  logic [NUM_PORTS*DCACHE_WAY_WIDTH-1:0]    hit_way_i,
  output logic [NUM_PORTS-1:0]                     hit_gnt_o,
  input  logic                                     miss_valid_i,
  input  logic [DCACHE_CL_IDX_WIDTH-1:0]           miss_idx_i,
  input  logic [1:0]                               miss_pred_i,
  output logic                                     repl_hit_o,
  output logic [DCACHE_CL_IDX_WIDTH-1:0]           repl_hit_idx_o,
  output logic [DCACHE_WAY_WIDTH-1:0]              repl_hit_way_o,
  output logic                                     repl_miss_o,
  output logic [DCACHE_CL_IDX_WIDTH-1:0]           repl_miss_idx_o,
  output logic [1:0]                               repl_pred_o,
  input  logic [DCACHE_WAY_WIDTH-1:0]              repl_way_i,
  output logic [DCACHE_WAY_WIDTH-1:0]              victim_way_o,
  output logic [REPL_DROP_CNT_W-1:0]               drop_cnt_o
);

  localparam int unsigned IDX_W = DCACHE_CL_IDX_WIDTH;
  localparam int unsigned WAY_W = DCACHE_WAY_WIDTH;
  localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned NV_W  = $clog2(NUM_PORTS + 1);
  localparam logic [PTR_W-1:0] LAST_RST = PTR_W'(NUM_PORTS - 1);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]                 state_q, state_d;
  logic [PTR_W-1:0]           last_q, last_d, winner;
  logic [REPL_DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [REPL_DROP_CNT_W:0]   drop_sum;
  logic [NV_W-1:0]            num_valid, num_drop;
  logic                       active, any_valid, hint_hits_miss, grant_dropped;
  logic                       push, pop, match, fifo_empty, fifo_full, head_valid;
  logic [IDX_W-1:0]           win_idx, head_idx;
  logic [WAY_W-1:0]           win_way, head_way;

  // A raised flush_i clears the scheduler in the same cycle, not only from the next one.
  assign active  = (state_q == ST_RUN) && !flush_i;
  assign state_d = flush_i ? ST_FLUSH : ST_RUN;

  assign repl_miss_o     = miss_valid_i;
  assign repl_miss_idx_o = miss_idx_i;
  assign repl_pred_o     = miss_pred_i;
  assign victim_way_o    = repl_way_i;

  always_comb begin
    int unsigned p;
    hit_gnt_o = '0;
    winner    = last_q;
    any_valid = 1'b0;
    p         = 0;
    if (active) begin
      for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
        p = (32'(last_q) + k) % NUM_PORTS;
        if (!any_valid && hit_valid_i[PTR_W'(p)]) begin
          any_valid = 1'b1;
          winner    = PTR_W'(p);
        end
      end
    end
    if (any_valid) begin
      hit_gnt_o[winner] = 1'b1;
    end
  end

  assign win_idx = hit_idx_i[32'(winner)*IDX_W +: IDX_W];
  assign win_way = hit_way_i[32'(winner)*WAY_W +: WAY_W];

  always_comb begin
    num_valid = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      num_valid = num_valid + NV_W'(hit_valid_i[i]);
    end
  end

  // A hint aimed at the set being refilled is stale, so it is dropped rather than buffered.
  assign hint_hits_miss = miss_valid_i && (win_idx == miss_idx_i);
  assign push           = active && any_valid && !hint_hits_miss && !match && !fifo_full;
  assign grant_dropped  = hint_hits_miss || (!match && fifo_full);
  assign pop            = active && !miss_valid_i && !fifo_empty;

  assign repl_hit_o     = pop && head_valid;
  assign repl_hit_idx_o = head_idx;
  assign repl_hit_way_o = head_way;

  always_comb begin
    num_drop = '0;
    if (active && any_valid) begin
      num_drop = num_valid - NV_W'(1) + NV_W'(grant_dropped);
    end
    drop_sum   = {1'b0, drop_cnt_q} + (REPL_DROP_CNT_W+1)'(num_drop);
    drop_cnt_d = drop_sum[REPL_DROP_CNT_W] ? '1 : drop_sum[REPL_DROP_CNT_W-1:0];
  end

  always_comb begin
    last_d = last_q;
    if (!active) begin
      last_d = LAST_RST;
    end else if (any_valid) begin
      last_d = winner;
    end
  end

  assign drop_cnt_o = drop_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_RUN;
      last_q     <= LAST_RST;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  wt_dcache_repl_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) i_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (!active),
    .push_i       (push),
    .push_idx_i   (win_idx),
    .push_way_i   (win_way),
    .pop_i        (pop),
    .inval_i      (miss_valid_i),
    .inval_idx_i  (miss_idx_i),
    .match_o      (match),
    .head_idx_o   (head_idx),
    .head_way_o   (head_way),
    .head_valid_o (head_valid),
    .empty_o      (fifo_empty),
    .full_o       (fifo_full)
  );

endmodule

// File: tb/tb_wt_dcache_repl_sched.sv
// Directed test-plan scenarios followed by randomized traffic, checked against a queue-based model.
module tb_wt_dcache_repl_sched;
  import wt_cache_pkg::*;

  localparam int NP    = 3;
  localparam int DEPTH = 4;
  localparam int IW    = DCACHE_CL_IDX_WIDTH;
  localparam int WW    = DCACHE_WAY_WIDTH;
`ifdef WT_DCACHE_REPL_COALESCE_EN
  localparam bit Coalesce = 1'b1;
`else
  localparam bit Coalesce = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              flush_i;
  logic [NP-1:0]     hit_valid_i;
  logic [NP*IW-1:0]  hit_idx_i;
  logic [NP*WW-1:0]  hit_way_i;
  logic [NP-1:0]     hit_gnt_o;
  logic              miss_valid_i;
  logic [IW-1:0]     miss_idx_i;
  logic [1:0]        miss_pred_i;
  logic              repl_hit_o;
  logic [IW-1:0]     repl_hit_idx_o;
  logic [WW-1:0]     repl_hit_way_o;
  logic              repl_miss_o;
  logic [IW-1:0]     repl_miss_idx_o;
  logic [1:0]        repl_pred_o;
  logic [WW-1:0]     repl_way_i;
  logic [WW-1:0]     victim_way_o;
  logic [15:0]       drop_cnt_o;

  always #5 clk_i = ~clk_i;

  wt_dcache_repl_sched #(
    .NUM_PORTS  (NP),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .flush_i         (flush_i),
    .hit_valid_i     (hit_valid_i),
    .hit_idx_i       (hit_idx_i),
    .hit_way_i       (hit_way_i),
    .hit_gnt_o       (hit_gnt_o),
    .miss_valid_i    (miss_valid_i),
    .miss_idx_i      (miss_idx_i),
    .miss_pred_i     (miss_pred_i),
    .repl_hit_o      (repl_hit_o),
    .repl_hit_idx_o  (repl_hit_idx_o),
    .repl_hit_way_o  (repl_hit_way_o),
    .repl_miss_o     (repl_miss_o),
    .repl_miss_idx_o (repl_miss_idx_o),
    .repl_pred_o     (repl_pred_o),
    .repl_way_i      (repl_way_i),
    .victim_way_o    (victim_way_o),
    .drop_cnt_o      (drop_cnt_o)
  );

  typedef struct {
    logic [IW-1:0] idx;
    logic [WW-1:0] way;
    bit            valid;
  } entry_t;

  entry_t        mq[$];
  int            mLast = NP - 1;
  int            mDrops = 0;
  bit            mInFlush = 1'b0;
  int            expWin;
  int            checks = 0;
  int            failures = 0;
  int            hitCount = 0;
  logic [IW-1:0] lastHitIdx;
  logic [WW-1:0] lastHitWay;
  logic [NP-1:0] lastGnt;
  logic [NP-1:0] gntLog[3];

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mLast    = NP - 1;
    mDrops   = 0;
    mInFlush = 1'b0;
  endtask

  task automatic checkOutput();
    logic [NP-1:0] expGnt;
    bit            active;
    bit            expHit;
    active = !flush_i && !mInFlush;
    expWin = -1;
    if (active) begin
      for (int k = 1; k <= NP; k++) begin
        int p;
        p = (mLast + k) % NP;
        if (expWin < 0 && hit_valid_i[p]) expWin = p;
      end
    end
    expGnt = '0;
    if (expWin >= 0) expGnt[expWin] = 1'b1;
    checkVal("hit_gnt", 32'(hit_gnt_o), 32'(expGnt));
    expHit = active && !miss_valid_i && (mq.size() > 0) && mq[0].valid;
    checkVal("repl_hit", 32'(repl_hit_o), 32'(expHit));
    if (expHit) begin
      checkVal("repl_hit_idx", 32'(repl_hit_idx_o), 32'(mq[0].idx));
      checkVal("repl_hit_way", 32'(repl_hit_way_o), 32'(mq[0].way));
    end
    checkVal("repl_miss", 32'(repl_miss_o), 32'(miss_valid_i));
    if (miss_valid_i) begin
      checkVal("repl_miss_idx", 32'(repl_miss_idx_o), 32'(miss_idx_i));
      checkVal("repl_pred", 32'(repl_pred_o), 32'(miss_pred_i));
    end
    checkVal("victim_way", 32'(victim_way_o), 32'(repl_way_i));
    checkVal("drop_cnt", 32'(drop_cnt_o), 32'(mDrops));
    lastGnt = hit_gnt_o;
    if (repl_hit_o === 1'b1) begin
      hitCount++;
      lastHitIdx = repl_hit_idx_o;
      lastHitWay = repl_hit_way_o;
    end
  endtask

  // Model: grant by rotation, classify the granted hint, invalidate, pop, then push.
  task automatic modelStep();
    entry_t cand;
    bit     pushIt;
    int     drops;
    if (flush_i) begin
      mq.delete();
      mLast = NP - 1;
    end else if (!mInFlush) begin
      pushIt = 1'b0;
      drops  = 0;
      if (expWin >= 0) begin
        mLast      = expWin;
        drops      = $countones(hit_valid_i) - 1;
        cand.idx   = hit_idx_i[expWin*IW +: IW];
        cand.way   = hit_way_i[expWin*WW +: WW];
        cand.valid = 1'b1;
        if (miss_valid_i && cand.idx == miss_idx_i) begin
          drops++;
        end else begin
          bit dup;
          dup = 1'b0;
          foreach (mq[i]) if (mq[i].valid && mq[i].idx == cand.idx && mq[i].way == cand.way) dup = 1'b1;
          if (Coalesce && dup) begin
            pushIt = 1'b0;
          end else if (mq.size() == DEPTH) begin
            drops++;
          end else begin
            pushIt = 1'b1;
          end
        end
      end
      if (miss_valid_i) begin
        foreach (mq[i]) if (mq[i].idx == miss_idx_i) mq[i].valid = 1'b0;
      end else if (mq.size() > 0) begin
        void'(mq.pop_front());
      end
      if (pushIt) mq.push_back(cand);
      mDrops = (mDrops + drops > 65535) ? 65535 : mDrops + drops;
    end
    mInFlush = flush_i;
  endtask

  task automatic applyStimulus(input logic [NP-1:0] hv, input logic [NP*IW-1:0] hidx,
                               input logic [NP*WW-1:0] hway, input logic mv,
                               input logic [IW-1:0] midx, input logic [1:0] mpred,
                               input logic [WW-1:0] rway, input logic fl);
    hit_valid_i  = hv;
    hit_idx_i    = hidx;
    hit_way_i    = hway;
    miss_valid_i = mv;
    miss_idx_i   = midx;
    miss_pred_i  = mpred;
    repl_way_i   = rway;
    flush_i      = fl;
    @(negedge clk_i);
    checkOutput();
    modelStep();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus('0, '0, '0, 1'b0, '0, 2'd0, WW'(i), 1'b0);
  endtask

  task automatic portHint(input int port, input logic [IW-1:0] idx, input logic [WW-1:0] way,
                          input logic mv, input logic [IW-1:0] midx);
    logic [NP-1:0]    hv;
    logic [NP*IW-1:0] hidx;
    logic [NP*WW-1:0] hway;
    hv = '0;
    hidx = '0;
    hway = '0;
    hv[port] = 1'b1;
    hidx[port*IW +: IW] = idx;
    hway[port*WW +: WW] = way;
    applyStimulus(hv, hidx, hway, mv, midx, 2'd1, 2'd3, 1'b0);
  endtask

  function automatic logic [NP*IW-1:0] packIdx(input int a, input int b, input int c);
    return {IW'(c), IW'(b), IW'(a)};
  endfunction

  initial begin
    rst_ni = 1'b0;
    flush_i = 1'b0;
    hit_valid_i = '0;
    hit_idx_i = '0;
    hit_way_i = '0;
    miss_valid_i = 1'b0;
    miss_idx_i = '0;
    miss_pred_i = '0;
    repl_way_i = '0;
    modelReset();
    #2;
    checkVal("reset_repl_hit", 32'(repl_hit_o), 32'd0);
    checkVal("reset_drop_cnt", 32'(drop_cnt_o), 32'd0);
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    idle(3);

    // All ports valid for three cycles while a miss blocks draining
    for (int c = 0; c < 3; c++) begin
      applyStimulus(3'b111, packIdx(20 + 3*c, 21 + 3*c, 22 + 3*c), '0, 1'b1, IW'(200), 2'd2, 2'd1, 1'b0);
      gntLog[c] = lastGnt;
    end
    checkVal("rr_grant0", 32'(gntLog[0]), 32'b001);
    checkVal("rr_grant1", 32'(gntLog[1]), 32'b010);
    checkVal("rr_grant2", 32'(gntLog[2]), 32'b100);
    checkVal("rr_drop6", 32'(drop_cnt_o), 32'd6);
    idle(4);

    portHint(1, IW'(5), WW'(2), 1'b0, '0);
    checkVal("tp_gnt_port1", 32'(lastGnt), 32'b010);
    hitCount = 0;
    idle(1);
    checkVal("tp_hit_next", 32'(hitCount), 32'd1);
    checkVal("tp_hit_idx", 32'(lastHitIdx), 32'd5);
    checkVal("tp_hit_way", 32'(lastHitWay), 32'd2);

    // Fill the buffer under a held miss, overflow once, then release
    hitCount = 0;
    for (int i = 0; i < 4; i++) portHint(0, IW'(40 + i), WW'(i), 1'b1, IW'(200));
    checkVal("full_no_hit", 32'(hitCount), 32'd0);
    portHint(0, IW'(44), WW'(0), 1'b1, IW'(200));
    checkVal("full_drop", 32'(drop_cnt_o), 32'd7);
    idle(4);
    checkVal("drain4", 32'(hitCount), 32'd4);

    hitCount = 0;
    portHint(0, IW'(7), WW'(0), 1'b1, IW'(200));
    portHint(0, IW'(9), WW'(1), 1'b1, IW'(200));
    applyStimulus('0, '0, '0, 1'b1, IW'(7), 2'd0, 2'd2, 1'b0);
    idle(3);
    checkVal("inval_hits", 32'(hitCount), 32'd1);
    checkVal("inval_idx", 32'(lastHitIdx), 32'd9);

    // Flush with three buffered entries; last grant was port 1
    for (int i = 0; i < 3; i++) portHint(1, IW'(50 + i), WW'(1), 1'b1, IW'(200));
    hitCount = 0;
    applyStimulus('0, '0, '0, 1'b0, '0, 2'd0, 2'd0, 1'b1);
    idle(3);
    checkVal("flush_no_hit", 32'(hitCount), 32'd0);
    checkVal("flush_drop_kept", 32'(drop_cnt_o), 32'd7);
    applyStimulus(3'b111, packIdx(60, 61, 62), '0, 1'b0, '0, 2'd0, 2'd0, 1'b0);
    checkVal("flush_rr_port0", 32'(lastGnt), 32'b001);
    idle(2);

    hitCount = 0;
    portHint(0, IW'(3), WW'(1), 1'b0, '0);
    portHint(0, IW'(3), WW'(1), 1'b0, '0);
    idle(3);
    checkVal("dup_hits", 32'(hitCount), Coalesce ? 32'd1 : 32'd2);
    checkVal("dup_drops", 32'(drop_cnt_o), 32'd9);

    // Reset while draining discards the buffer at once
    for (int i = 0; i < 3; i++) portHint(2, IW'(70 + i), WW'(2), 1'b1, IW'(200));
    idle(1);
    rst_ni = 1'b0;
    #1;
    modelReset();
    checkVal("mid_rst_hit", 32'(repl_hit_o), 32'd0);
    checkVal("mid_rst_drop", 32'(drop_cnt_o), 32'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    hitCount = 0;
    idle(3);
    checkVal("post_rst_no_hit", 32'(hitCount), 32'd0);

    for (int n = 0; n < 3000; n++) begin
      logic [NP*IW-1:0] hidx;
      hidx = '0;
      for (int p = 0; p < NP; p++) hidx[p*IW +: IW] = IW'($urandom_range(0, 7));
      applyStimulus(NP'($urandom_range(0, 7)), hidx, (NP*WW)'($urandom),
                    $urandom_range(0, 99) < 30, IW'($urandom_range(0, 7)),
                    2'($urandom), WW'($urandom), $urandom_range(0, 99) < 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wt_dcache_repl_sched.md
# wt_dcache_repl_sched

Update scheduler for the write-through dcache replacement-state array (SRRIP, 4-way). It sits between the dcache read ports and the miss unit on one side and the replacement array's single update port on the other. Misses pass straight through with priority. Hit hints from NUM_PORTS read ports are round-robin arbitrated, buffered and replayed in idle cycles, so a hit coinciding with a miss fill is deferred rather than lost.

## Interface
- NUM_PORTS, 3, number of hit-hint requesters
- FIFO_DEPTH, 4, hit-hint buffer entries (power of two, ≥2)
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- flush_i  in  1  cache flush; clears scheduler state
- hit_valid_i  in  NUM_PORTS  hit hint valid per port
- hit_idx_i  in  NUM_PORTS×DCACHE_CL_IDX_WIDTH  hit set index per port
- hit_way_i  in  NUM_PORTS×$clog2(DCACHE_SET_ASSOC)  hit way per port
- hit_gnt_o  out  NUM_PORTS  one-hot, combinational; hint accepted into arbitration
- miss_valid_i  in  1  miss fill needs victim
- miss_idx_i  in  DCACHE_CL_IDX_WIDTH  miss set index
- miss_pred_i  in  2  insertion RRPV prediction
- repl_hit_o / repl_hit_idx_o / repl_hit_way_o  out  1/IDX/WAY  hit update to array
- repl_miss_o / repl_miss_idx_o / repl_pred_o  out  1/IDX/2  miss update to array
- repl_way_i  in  WAY  victim way from array
- victim_way_o  out  WAY  victim way to miss unit, valid with miss_valid_i
- drop_cnt_o  out  16  saturating count of dropped hints

## Operation
- States: RUN, FLUSH. Reset → RUN. flush_i in any state → FLUSH. In FLUSH: FIFO cleared, RR pointer reset, hit_gnt_o=0, repl_hit_o=0. Leave FLUSH → RUN on the first cycle with flush_i low.
- Miss path is combinational passthrough in any state:
  - repl_miss_o=miss_valid_i; idx/pred forwarded.
  - victim_way_o=repl_way_i.
- Arbitration (RUN only):
  - Round-robin among asserted hit_valid_i; the first requester after last_q wins.
  - last_q updates to the winner on every grant.
  - Reset value of last_q is NUM_PORTS-1, so port 0 wins first.
  - Non-granted valid hints are dropped; drop_cnt_o += number dropped.
- Enqueue: the granted hint is written if count_q<FIFO_DEPTH. If the FIFO is full, the hint is dropped and counted; there is no bypass, even when a dequeue occurs that cycle.
- Miss invalidation:
  - A miss to index X clears the valid bit of every buffered entry with idx==X.
  - A hint granted in the same cycle with idx==X is dropped and counted.
- Dequeue: only when miss_valid_i=0 and state=RUN.
  - Head valid → repl_hit_o=1 with head idx/way, then pop.
  - Head invalidated → pop silently with repl_hit_o=0, one entry per cycle.
- repl_hit_o and repl_miss_o are never both 1.
- drop_cnt_o saturates at 16'hFFFF, is cleared only by reset, and is not cleared by flush.

## Timing
- Reset values: repl_hit_o=0, FIFO empty, drop_cnt_o=0, state RUN, last_q=NUM_PORTS-1.
- Hint granted in cycle N → earliest repl_hit_o in cycle N+1.
- Each miss cycle delays drain by one cycle.
- Miss/victim path: zero latency.
- Asserting rst_ni mid-drain discards all entries immediately.
- Simultaneous enqueue and dequeue while not full: both occur, count unchanged.

## Configuration
- WT_DCACHE_REPL_COALESCE_EN defined:
  - A granted hint whose {idx,way} matches a valid buffered entry is merged.
  - A merged hint is granted, not enqueued and not counted as dropped.
- WT_DCACHE_REPL_COALESCE_EN undefined: duplicates occupy separate entries.

## Structure
- wt_cache_pkg: repl_hint_t struct {idx, way} and the REPL_DROP_CNT_W=16 constant.
- Sub-module wt_dcache_repl_fifo holds the circular buffer, with:
  - per-entry valid bits;
  - a parallel index-match invalidate;
  - the optional match lookup.
- The arbiter and FSM live in the top.

## Test plan
- Port 1 hint idx=5 way=2 at cycle 10 → hit_gnt_o=3'b010; repl_hit_o at cycle 11 with idx=5 way=2.
- All 3 ports valid for 3 consecutive cycles → grants to ports 0,1,2 in order; 6 hints dropped, drop_cnt_o=6.
- 4 hints enqueued while miss_valid_i held high → no repl_hit_o. Then a 5th hint → dropped. Miss released → 4 hit updates on 4 consecutive cycles.
- Buffered hints at idx=7 and idx=9, then a miss to idx=7 → only the idx=9 update is issued; the idx=7 slot is popped silently.
- flush_i pulse with 3 entries buffered → no repl_hit_o afterwards; the next hint goes to port 0; drop_cnt_o is unchanged.
- Coalescing enabled: same {idx=3, way=1} from two consecutive cycles → one repl_hit_o, drop_cnt_o=0. Disabled → two repl_hit_o.
